// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, polarity encodings and the sync/active bundle
// carried through the output delay line.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam bit SYNC_NEG = 1'b0;
    localparam bit SYNC_POS = 1'b1;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Pin-level bundle: hs/vs already carry the configured polarity.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_bundle_t;

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Enabled shift register with a synchronous reset value; DEPTH = 0 is a
// plain combinational pass-through.
module delay_line #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst, en, rst_val};
        assign q = d;
    end else begin : g_shift
        logic [W-1:0] stage_q [DEPTH];
        logic [W-1:0] stage_d [DEPTH];

        always_comb begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i];
            end
            if (en) begin
                stage_d[0] = d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= rst_val;
                end
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: x/y/frame counters, sync/active decodes
// delayed to match the fetch pipeline, and per-tick line/frame event pulses.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = SYNC_NEG,
    parameter bit          V_POL    = SYNC_NEG,
    parameter int unsigned CW       = 10,
    parameter int unsigned PIPE     = 2,
    parameter int unsigned FW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active,
    output logic          line_end,
    output logic          animate,
    output logic          frame_end,
    output logic [FW-1:0] frame
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

    if (CW >= 32 || H_TOTAL > (32'd1 << CW) || V_TOTAL > (32'd1 << CW) || PIPE > 8)
    begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: CW too small for the totals or PIPE > 8");
    end

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          x_last, y_last, y_anim;
    logic          hs_raw, vs_raw, act_raw;
    sync_bundle_t  raw_s, idle_s, dly_s;

    assign x_last = (32'(x_q) == H_TOTAL - 1);
    assign y_last = (32'(y_q) == V_TOTAL - 1);
    assign y_anim = (32'(y_q) == V_ACTIVE - 1);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (pix_en) begin
            if (x_last) begin
                x_d = '0;
                if (y_last) begin
                    y_d     = '0;
                    frame_d = frame_q + FW'(1);
                end else begin
                    y_d = y_q + CW'(1);
                end
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        hs_raw  = (32'(x_q) >= HS_BEG) && (32'(x_q) < HS_END);
        vs_raw  = (32'(y_q) >= VS_BEG) && (32'(y_q) < VS_END);
        act_raw = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);

        raw_s.hs   = hs_raw ? H_POL : ~H_POL;
        raw_s.vs   = vs_raw ? V_POL : ~V_POL;
        raw_s.act  = act_raw;

        idle_s.hs  = ~H_POL;
        idle_s.vs  = ~V_POL;
        idle_s.act = 1'b0;
    end

    // Polarity is applied before the delay so the reset value is simply "idle pins".
    delay_line #(
        .W     (3),
        .DEPTH (PIPE)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .en      (pix_en),
        .rst_val (idle_s),
        .d       (raw_s),
        .q       (dly_s)
    );

    always_comb begin
        line_end  = 1'b0;
        animate   = 1'b0;
        frame_end = 1'b0;
        if (pix_en && !rst && x_last) begin
            line_end  = 1'b1;
            animate   = y_anim;
            frame_end = y_last;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign frame  = frame_q;
    assign h_sync = dly_s.hs;
    assign v_sync = dly_s.vs;
    assign active = dly_s.act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing at PIPE 0/2/3 and
// a tiny raster (8x6 totals, positive sync, PIPE 1, FW 2) for frame-level events.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, en0, rst2, en2, rst_s, en_s;

    logic [9:0]  d0_x, d0_y, d3_x, d3_y, d2_x, d2_y;
    logic [15:0] d0_fr, d3_fr, d2_fr;
    logic d0_hs, d0_vs, d0_act, d0_le, d0_an, d0_fe;
    logic d3_hs, d3_vs, d3_act, d3_le, d3_an, d3_fe;
    logic d2_hs, d2_vs, d2_act, d2_le, d2_an, d2_fe;
    logic [3:0] s_x, s_y;
    logic [1:0] s_fr;
    logic s_hs, s_vs, s_act, s_le, s_an, s_fe;

    vga_timing_gen #(.PIPE(0)) u_d0 (
        .clk(clk), .rst(rst0), .pix_en(en0), .x(d0_x), .y(d0_y),
        .h_sync(d0_hs), .v_sync(d0_vs), .active(d0_act), .line_end(d0_le),
        .animate(d0_an), .frame_end(d0_fe), .frame(d0_fr)
    );

    vga_timing_gen #(.PIPE(3)) u_d3 (
        .clk(clk), .rst(rst0), .pix_en(en0), .x(d3_x), .y(d3_y),
        .h_sync(d3_hs), .v_sync(d3_vs), .active(d3_act), .line_end(d3_le),
        .animate(d3_an), .frame_end(d3_fe), .frame(d3_fr)
    );

    vga_timing_gen #(.PIPE(2)) u_d2 (
        .clk(clk), .rst(rst2), .pix_en(en2), .x(d2_x), .y(d2_y),
        .h_sync(d2_hs), .v_sync(d2_vs), .active(d2_act), .line_end(d2_le),
        .animate(d2_an), .frame_end(d2_fe), .frame(d2_fr)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .PIPE(1), .FW(2)
    ) u_sm (
        .clk(clk), .rst(rst_s), .pix_en(en_s), .x(s_x), .y(s_y),
        .h_sync(s_hs), .v_sync(s_vs), .active(s_act), .line_end(s_le),
        .animate(s_an), .frame_end(s_fe), .frame(s_fr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned en;
        int unsigned x, y;
        int unsigned le, an, fe;
        int unsigned fr;
        int unsigned hs, vs, act;
    } vec_t;

    function automatic vec_t mk(int unsigned en, int unsigned xx, int unsigned yy,
                                int unsigned le, int unsigned an, int unsigned fe,
                                int unsigned fr, int unsigned hs, int unsigned vs,
                                int unsigned act);
        vec_t v;
        v.en = en; v.x = xx; v.y = yy; v.le = le; v.an = an; v.fe = fe;
        v.fr = fr; v.hs = hs; v.vs = vs; v.act = act;
        return v;
    endfunction

    function automatic int unsigned def_hs(int xx);
        return (xx >= 656 && xx < 752) ? 0 : 1;
    endfunction

    vec_t tbl[13];

    // Tiny-raster model state
    int mx, my, mf, tick_cnt, c_le, c_an, c_act, frames_seen;
    bit started, cont_phase;
    logic pm_hs, pm_vs, pm_act;
    int fr_seq[$];

    task automatic small_cycle(input logic en);
        en_s = en;
        #1;
        chk("sm_x", 32'(s_x), mx);
        chk("sm_y", 32'(s_y), my);
        chk("sm_frame", 32'(s_fr), mf);
        chk("sm_line_end", 32'(s_le), (en && mx == 7) ? 1 : 0);
        chk("sm_animate", 32'(s_an), (en && mx == 7 && my == 2) ? 1 : 0);
        chk("sm_frame_end", 32'(s_fe), (en && mx == 7 && my == 5) ? 1 : 0);
        chk("sm_h_sync", 32'(s_hs), 32'(pm_hs));
        chk("sm_v_sync", 32'(s_vs), 32'(pm_vs));
        chk("sm_active", 32'(s_act), 32'(pm_act));
        if (en) begin
            if (cont_phase && mx == 0 && my == 0) fr_seq.push_back(32'(s_fr));
            tick_cnt++;
            c_le += 32'(s_le);
            c_an += 32'(s_an);
            c_act += 32'(s_act);
            if (s_fe) begin
                if (started) begin
                    chk("frame_ticks", tick_cnt, 48);
                    chk("frame_line_ends", c_le, 6);
                    chk("frame_animates", c_an, 1);
                    chk("frame_active_ticks", c_act, 12);
                    frames_seen++;
                end
                started = 1'b1;
                tick_cnt = 0; c_le = 0; c_an = 0; c_act = 0;
            end
            pm_hs  = (mx >= 5 && mx < 7);
            pm_vs  = (my == 4);
            pm_act = (mx < 4 && my < 3);
            if (mx == 7) begin
                mx = 0;
                if (my == 5) begin
                    my = 0;
                    mf = (mf + 1) % 4;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b1; en0 = 1'b1;
        rst2 = 1'b1; en2 = 1'b1;
        rst_s = 1'b1; en_s = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state of the default-timing generators
        chk("rst_d3_x", 32'(d3_x), 0);
        chk("rst_d3_y", 32'(d3_y), 0);
        chk("rst_d3_frame", 32'(d3_fr), 0);
        chk("rst_d3_h_sync", 32'(d3_hs), 1);
        chk("rst_d3_v_sync", 32'(d3_vs), 1);
        chk("rst_d3_active", 32'(d3_act), 0);
        chk("rst_d0_line_end", 32'(d0_le), 0);
        rst0 = 1'b0;
        #1;
        chk("post_rst_d0_x", 32'(d0_x), 0);
        chk("post_rst_d0_frame", 32'(d0_fr), 0);

        // Line 0: PIPE 0 raw decodes and PIPE 3 delayed copy
        for (int i = 0; i < 800; i++) begin
            chk("d0_x", 32'(d0_x), i);
            chk("d0_y", 32'(d0_y), 0);
            chk("d0_h_sync", 32'(d0_hs), def_hs(i));
            chk("d0_v_sync", 32'(d0_vs), 1);
            chk("d0_active", 32'(d0_act), (i < 640) ? 1 : 0);
            chk("d0_line_end", 32'(d0_le), (i == 799) ? 1 : 0);
            chk("d3_h_sync", 32'(d3_hs), (i < 3) ? 1 : def_hs(i - 3));
            chk("d3_active", 32'(d3_act), (i >= 3 && i - 3 < 640) ? 1 : 0);
            @(negedge clk);
            #1;
        end
        chk("d0_wrap_x", 32'(d0_x), 0);
        chk("d0_wrap_y", 32'(d0_y), 1);
        chk("d0_animate", 32'(d0_an), 0);

        // Mid-frame reset on the PIPE 2 instance
        @(negedge clk);
        rst2 = 1'b0;
        repeat (1900) @(negedge clk);
        #1;
        chk("d2_pre_x", 32'(d2_x), 300);
        chk("d2_pre_y", 32'(d2_y), 2);
        chk("d2_pre_active", 32'(d2_act), 1);
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("d2_rst_x", 32'(d2_x), 0);
        chk("d2_rst_y", 32'(d2_y), 0);
        chk("d2_rst_active_t0", 32'(d2_act), 0);
        chk("d2_rst_h_sync_t0", 32'(d2_hs), 1);
        chk("d2_rst_v_sync_t0", 32'(d2_vs), 1);
        @(negedge clk);
        #1;
        chk("d2_rst_x_t1", 32'(d2_x), 1);
        chk("d2_rst_active_t1", 32'(d2_act), 0);
        @(negedge clk);
        #1;
        chk("d2_rst_active_t2", 32'(d2_act), 1);
        chk("d2_rst_h_sync_t2", 32'(d2_hs), 1);

        // Tiny raster: hand-computed vectors with pix_en gaps
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 6, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 7, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[10] = mk(1, 7, 0, 1, 0, 0, 0, 1, 0, 0);
        tbl[11] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        rst_s = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            en_s = (tbl[k].en != 0);
            #1;
            chk("tv_x", 32'(s_x), tbl[k].x);
            chk("tv_y", 32'(s_y), tbl[k].y);
            chk("tv_line_end", 32'(s_le), tbl[k].le);
            chk("tv_animate", 32'(s_an), tbl[k].an);
            chk("tv_frame_end", 32'(s_fe), tbl[k].fe);
            chk("tv_frame", 32'(s_fr), tbl[k].fr);
            chk("tv_h_sync", 32'(s_hs), tbl[k].hs);
            chk("tv_v_sync", 32'(s_vs), tbl[k].vs);
            chk("tv_active", 32'(s_act), tbl[k].act);
        end

        // Continuous run from a fresh reset: frame sequence and per-frame events
        @(negedge clk);
        rst_s = 1'b1; en_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        mx = 0; my = 0; mf = 0;
        pm_hs = 1'b0; pm_vs = 1'b0; pm_act = 1'b0;
        tick_cnt = 0; c_le = 0; c_an = 0; c_act = 0; frames_seen = 0;
        started = 1'b0; cont_phase = 1'b1;
        for (int c = 0; c < 200; c++) small_cycle(1'b1);
        chk("seq_len", fr_seq.size(), 5);
        for (int j = 0; j < 5 && j < fr_seq.size(); j++) begin
            chk("frame_seq", fr_seq[j], (j == 4) ? 0 : j);
        end
        chk("cont_frames", frames_seen, 3);

        // pix_en only on every 4th cycle, with random drops
        cont_phase = 1'b0;
        frames_seen = 0;
        for (int c = 0; c < 1300; c++) begin
            small_cycle((c % 4 == 0) && ($urandom_range(0, 3) != 0));
        end
        chk("gap_frames_ge2", (frames_seen >= 2) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
